// File: rtl/mips_core_pkg.sv
// rtl/mips_core_pkg.sv - shared tag types and sizes for the rename stage
package mips_core_pkg;
  localparam int N_PREG   = 64;
  localparam int AL_DEPTH = 32;
  localparam int FL_DEPTH = 32;
  localparam int N_AREG   = 32;

  typedef logic [5:0] preg_t;
  typedef logic [4:0] al_idx_t;
  typedef logic [4:0] areg_t;
  typedef logic [5:0] ptr_t;

  // Per-slot record of what a renamed instruction will commit into the architectural map.
  typedef struct packed {
    logic  has_dst;
    areg_t areg;
    preg_t preg;
  } al_entry_t;
endpackage

// File: rtl/rename_free_list.sv
// rtl/rename_free_list.sv - circular free-tag FIFO with a committed head for flush recovery
module rename_free_list
  import mips_core_pkg::*;
#(
  parameter int BASE_TAG = N_PREG - FL_DEPTH
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  pop,
  input  logic  push,
  input  preg_t push_tag,
  input  logic  commit,
  input  logic  restore,
  output preg_t head_tag,
  output ptr_t  count
);

  ptr_t  head;
  ptr_t  tail;
  ptr_t  commit_head;
  ptr_t  commit_head_next;
  preg_t entries [FL_DEPTH];

  assign commit_head_next = commit_head + ptr_t'(commit);
  assign head_tag         = entries[head[4:0]];
  assign count            = tail - head;

  // Tags between commit_head and head belong to uncommitted renames; restore hands them back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head        <= '0;
      commit_head <= '0;
      tail        <= ptr_t'(FL_DEPTH);
      for (int i = 0; i < FL_DEPTH; i++) begin
        entries[i] <= preg_t'(BASE_TAG + i);
      end
    end else begin
      if (restore) begin
        head <= commit_head_next;
      end else if (pop) begin
        head <= head + 6'd1;
      end
      commit_head <= commit_head_next;
      if (push) begin
        entries[tail[4:0]] <= push_tag;
        tail               <= tail + 6'd1;
      end
    end
  end

endmodule

// File: rtl/register_rename.sv
// rtl/register_rename.sv - speculative/architectural map rename stage; RENAME_PERF_EN adds stall counters
module register_rename
  import mips_core_pkg::*;
#(
  parameter int N_PREG   = mips_core_pkg::N_PREG,
  parameter int AL_DEPTH = mips_core_pkg::AL_DEPTH
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_uses_rs,
  input  logic        in_uses_rt,
  input  logic        in_uses_rw,
  input  logic [4:0]  in_rs_addr,
  input  logic [4:0]  in_rt_addr,
  input  logic [4:0]  in_rw_addr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [5:0]  out_src0_preg,
  output logic [5:0]  out_src1_preg,
  output logic [5:0]  out_dst_preg,
  output logic [5:0]  out_old_dst_preg,
  output logic        out_has_dst,
  output logic [4:0]  out_al_index,
  input  logic        retire_valid,
  input  logic        retire_has_dst,
  input  logic [5:0]  retire_old_preg,
  input  logic        flush
`ifdef RENAME_PERF_EN
  ,
  output logic [31:0] perf_fl_stall,
  output logic [31:0] perf_al_stall
`endif
);

  localparam ptr_t AL_MAX = ptr_t'(AL_DEPTH);

  preg_t     spec_map [N_AREG];
  preg_t     arch_map [N_AREG];
  al_entry_t al_mem   [AL_DEPTH];
  al_idx_t   alloc_ptr;
  al_idx_t   commit_ptr;
  ptr_t      al_count;
  preg_t     fl_head;
  ptr_t      fl_count;
  logic      needs_dst;
  logic      fl_empty;
  logic      al_full;
  logic      fire;
  logic      ret_dst;
  logic      arch_wr;
  al_entry_t ret_entry;

  assign needs_dst = in_uses_rw && (in_rw_addr != 5'd0);
  assign fl_empty  = (fl_count == 6'd0);
  assign al_full   = (al_count >= AL_MAX);
  assign in_ready  = rst_n && (!out_valid || out_ready) && !al_full && (!fl_empty || !needs_dst);
  assign fire      = in_valid && in_ready && !flush;
  assign ret_dst   = retire_valid && retire_has_dst;
  assign ret_entry = al_mem[commit_ptr];
  assign arch_wr   = retire_valid && ret_entry.has_dst;

  rename_free_list #(
    .BASE_TAG(N_PREG - FL_DEPTH)
  ) u_free_list (
    .clk      (clk),
    .rst_n    (rst_n),
    .pop      (fire && needs_dst),
    .push     (ret_dst),
    .push_tag (retire_old_preg),
    .commit   (ret_dst),
    .restore  (flush),
    .head_tag (fl_head),
    .count    (fl_count)
  );

  // Active-list payload needs no reset: a slot is always written before it can be retired.
  always_ff @(posedge clk) begin
    if (fire) begin
      al_mem[alloc_ptr] <= '{has_dst: needs_dst, areg: in_rw_addr, preg: fl_head};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_AREG; i++) begin
        spec_map[i] <= preg_t'(i);
        arch_map[i] <= preg_t'(i);
      end
      alloc_ptr        <= '0;
      commit_ptr       <= '0;
      al_count         <= '0;
      out_valid        <= 1'b0;
      out_src0_preg    <= '0;
      out_src1_preg    <= '0;
      out_dst_preg     <= '0;
      out_old_dst_preg <= '0;
      out_has_dst      <= 1'b0;
      out_al_index     <= '0;
    end else begin
      if (arch_wr) begin
        arch_map[ret_entry.areg] <= ret_entry.preg;
      end
      if (retire_valid) begin
        commit_ptr <= commit_ptr + 5'd1;
      end
      if (flush) begin
        // Recovery includes a retire landing in the same cycle.
        out_valid <= 1'b0;
        for (int i = 0; i < N_AREG; i++) begin
          spec_map[i] <= (arch_wr && ret_entry.areg == areg_t'(i)) ? ret_entry.preg : arch_map[i];
        end
        alloc_ptr <= commit_ptr + al_idx_t'(retire_valid);
        al_count  <= '0;
      end else begin
        if (fire) begin
          out_valid        <= 1'b1;
          out_src0_preg    <= in_uses_rs ? spec_map[in_rs_addr] : '0;
          out_src1_preg    <= in_uses_rt ? spec_map[in_rt_addr] : '0;
          out_has_dst      <= needs_dst;
          out_dst_preg     <= needs_dst ? fl_head : '0;
          out_old_dst_preg <= needs_dst ? spec_map[in_rw_addr] : '0;
          out_al_index     <= alloc_ptr;
          alloc_ptr        <= alloc_ptr + 5'd1;
          if (needs_dst) begin
            spec_map[in_rw_addr] <= fl_head;
          end
        end else if (out_ready) begin
          out_valid <= 1'b0;
        end
        al_count <= al_count + ptr_t'(fire) - ptr_t'(retire_valid);
      end
    end
  end

`ifdef RENAME_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fl_stall <= '0;
      perf_al_stall <= '0;
    end else begin
      if (in_valid && !in_ready && needs_dst && fl_empty && perf_fl_stall != 32'hFFFF_FFFF) begin
        perf_fl_stall <= perf_fl_stall + 32'd1;
      end
      if (in_valid && !in_ready && al_full && perf_al_stall != 32'hFFFF_FFFF) begin
        perf_al_stall <= perf_al_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_register_rename.sv
// tb/tb_register_rename.sv - randomized self-checking bench for register_rename
module tb_register_rename;

  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, in_uses_rs, in_uses_rt, in_uses_rw;
  logic [4:0] in_rs_addr, in_rt_addr, in_rw_addr;
  logic out_valid, out_ready;
  logic [5:0] out_src0_preg, out_src1_preg, out_dst_preg, out_old_dst_preg;
  logic out_has_dst;
  logic [4:0] out_al_index;
  logic retire_valid, retire_has_dst;
  logic [5:0] retire_old_preg;
  logic flush;

  register_rename dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_uses_rs(in_uses_rs), .in_uses_rt(in_uses_rt), .in_uses_rw(in_uses_rw),
    .in_rs_addr(in_rs_addr), .in_rt_addr(in_rt_addr), .in_rw_addr(in_rw_addr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_src0_preg(out_src0_preg), .out_src1_preg(out_src1_preg),
    .out_dst_preg(out_dst_preg), .out_old_dst_preg(out_old_dst_preg),
    .out_has_dst(out_has_dst), .out_al_index(out_al_index),
    .retire_valid(retire_valid), .retire_has_dst(retire_has_dst),
    .retire_old_preg(retire_old_preg), .flush(flush)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: maps as arrays, free list and active list as queues.
  typedef struct { int areg; int dst; int old; bit has; } ent_t;
  int   map_m [32];
  int   arch_m [32];
  int   fl_q [$];
  ent_t al_q [$];
  int   alloc_cnt, commit_cnt;

  logic        ready_seen;
  logic [29:0] got;
  logic        got_valid;

  function automatic logic [29:0] bundle();
    return {out_src0_preg, out_src1_preg, out_dst_preg, out_old_dst_preg, out_has_dst, out_al_index};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin map_m[i] = i; arch_m[i] = i; end
    fl_q.delete();
    for (int i = 32; i < 64; i++) fl_q.push_back(i);
    al_q.delete();
    alloc_cnt = 0;
    commit_cnt = 0;
  endtask

  function automatic bit model_ready(input bit uw, input int rw);
    return (al_q.size() < 32) && (fl_q.size() > 0 || !(uw && rw != 0));
  endfunction

  task automatic model_rename(input int rs, input int rt, input int rw, input bit us, input bit ut,
                              input bit uw, output logic [29:0] exp_b);
    int s0, s1, d, o;
    bit h;
    s0 = us ? map_m[rs] : 0;
    s1 = ut ? map_m[rt] : 0;
    h = uw && (rw != 0);
    d = 0;
    o = 0;
    if (h) begin
      d = fl_q.pop_front();
      o = map_m[rw];
      map_m[rw] = d;
    end
    al_q.push_back('{areg: rw, dst: d, old: o, has: h});
    exp_b = {6'(s0), 6'(s1), 6'(d), 6'(o), h, 5'(alloc_cnt % 32)};
    alloc_cnt++;
  endtask

  task automatic model_flush();
    int tmp [$];
    foreach (al_q[i]) if (al_q[i].has) tmp.push_back(al_q[i].dst);
    fl_q = {tmp, fl_q};
    al_q.delete();
    for (int i = 0; i < 32; i++) map_m[i] = arch_m[i];
    alloc_cnt = commit_cnt;
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_uses_rs = 0; in_uses_rt = 0; in_uses_rw = 0;
    in_rs_addr = 0; in_rt_addr = 0; in_rw_addr = 0;
    retire_valid = 0; retire_has_dst = 0; retire_old_preg = 0; flush = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle_inputs();
    out_ready = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1;
    model_reset();
  endtask

  task automatic drive_rename(input int rs, input int rt, input int rw, input bit us, input bit ut, input bit uw);
    in_rs_addr = 5'(rs); in_rt_addr = 5'(rt); in_rw_addr = 5'(rw);
    in_uses_rs = us; in_uses_rt = ut; in_uses_rw = uw;
    in_valid = 1;
    #1 ready_seen = in_ready;
    @(posedge clk); #1;
    in_valid = 0;
    got = bundle();
    got_valid = out_valid;
  endtask

  task automatic drive_retire();
    ent_t e;
    e = al_q.pop_front();
    retire_valid = 1;
    retire_has_dst = e.has;
    retire_old_preg = 6'(e.old);
    @(posedge clk); #1;
    retire_valid = 0; retire_has_dst = 0; retire_old_preg = 0;
    if (e.has) begin
      fl_q.push_back(e.old);
      arch_m[e.areg] = e.dst;
    end
    commit_cnt++;
  endtask

  task automatic drive_flush(input int rw);
    flush = 1;
    in_valid = 1; in_uses_rw = 1; in_rw_addr = 5'(rw);
    @(posedge clk); #1;
    flush = 0;
    idle_inputs();
    model_flush();
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle_inputs();
    out_ready = 1;
    in_valid = 1; in_uses_rw = 1; in_rw_addr = 3;
    #1;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got=%b exp=0", in_ready); else n_pass++;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 0;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else n_pass++;
    n_checks++; if (bundle() !== 30'd0) $display("FAIL reset_out_tags got=%h exp=0", bundle()); else n_pass++;
    rst_n = 1;
    model_reset();
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); else n_pass++;
  endtask

  task automatic test_basic();
    logic [29:0] e;
    do_reset();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL basic_pre_valid got=%b exp=0", out_valid); else n_pass++;
    drive_rename(1, 2, 3, 1, 1, 1);
    model_rename(1, 2, 3, 1, 1, 1, e);
    n_checks++; if (got_valid !== 1'b1) $display("FAIL basic_valid got=%b exp=1", got_valid); else n_pass++;
    n_checks++;
    if (got !== {6'd1, 6'd2, 6'd32, 6'd3, 1'b1, 5'd0}) $display("FAIL basic_add got=%h exp=%h", got, {6'd1, 6'd2, 6'd32, 6'd3, 1'b1, 5'd0});
    else n_pass++;
    n_checks++; if (got !== e) $display("FAIL basic_model got=%h exp=%h", got, e); else n_pass++;
  endtask

  task automatic test_same_reg();
    logic [29:0] e;
    do_reset();
    drive_rename(3, 3, 3, 1, 1, 1);
    model_rename(3, 3, 3, 1, 1, 1, e);
    n_checks++; if (got !== e) $display("FAIL same_reg_first got=%h exp=%h", got, e); else n_pass++;
    drive_rename(3, 3, 3, 1, 1, 1);
    model_rename(3, 3, 3, 1, 1, 1, e);
    n_checks++;
    if ({out_src0_preg, out_src1_preg, out_dst_preg, out_old_dst_preg} !== {6'd32, 6'd32, 6'd33, 6'd32})
      $display("FAIL same_reg_second got=%h exp=%h", {out_src0_preg, out_src1_preg, out_dst_preg, out_old_dst_preg}, {6'd32, 6'd32, 6'd33, 6'd32});
    else n_pass++;
  endtask

  task automatic test_r0();
    logic [29:0] e;
    do_reset();
    drive_rename(1, 0, 0, 1, 0, 1);
    model_rename(1, 0, 0, 1, 0, 1, e);
    n_checks++; if (out_has_dst !== 1'b0) $display("FAIL r0_has_dst got=%b exp=0", out_has_dst); else n_pass++;
    n_checks++; if (got !== e) $display("FAIL r0_model got=%h exp=%h", got, e); else n_pass++;
    drive_rename(0, 0, 5, 0, 0, 1);
    model_rename(0, 0, 5, 0, 0, 1, e);
    n_checks++; if (out_dst_preg !== 6'd32) $display("FAIL r0_head_kept got=%0d exp=32", out_dst_preg); else n_pass++;
    n_checks++; if (got !== e) $display("FAIL r0_next_model got=%h exp=%h", got, e); else n_pass++;
  endtask

  task automatic test_fill();
    logic [29:0] e;
    int rw;
    do_reset();
    for (int i = 0; i < 32; i++) begin
      rw = (i == 0) ? 3 : (i % 31) + 1;
      drive_rename(rw, 0, rw, 1, 0, 1);
      model_rename(rw, 0, rw, 1, 0, 1, e);
      n_checks++; if (!ready_seen || got !== e) $display("FAIL fill_%0d got=%h rdy=%b exp=%h", i, got, ready_seen, e); else n_pass++;
    end
    drive_rename(0, 0, 5, 0, 0, 1);
    n_checks++; if (ready_seen !== 1'b0) $display("FAIL fill_33rd_ready got=%b exp=0", ready_seen); else n_pass++;
    drive_retire();
    drive_rename(0, 0, 5, 0, 0, 1);
    model_rename(0, 0, 5, 0, 0, 1, e);
    n_checks++; if (ready_seen !== 1'b1) $display("FAIL fill_after_retire_ready got=%b exp=1", ready_seen); else n_pass++;
    n_checks++; if (out_dst_preg !== 6'd3) $display("FAIL fill_recycled_dst got=%0d exp=3", out_dst_preg); else n_pass++;
    n_checks++; if (got !== e) $display("FAIL fill_recycled_model got=%h exp=%h", got, e); else n_pass++;
  endtask

  task automatic test_flush();
    logic [29:0] e;
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      drive_rename(0, 0, i, 0, 0, 1);
      model_rename(0, 0, i, 0, 0, 1, e);
    end
    drive_retire();
    drive_retire();
    drive_flush(9);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL flush_out_valid got=%b exp=0", out_valid); else n_pass++;
    drive_rename(1, 2, 7, 1, 1, 1);
    model_rename(1, 2, 7, 1, 1, 1, e);
    n_checks++; if (out_dst_preg !== 6'd34) $display("FAIL flush_next_dst got=%0d exp=34", out_dst_preg); else n_pass++;
    n_checks++; if (out_al_index !== 5'd2) $display("FAIL flush_al_index got=%0d exp=2", out_al_index); else n_pass++;
    n_checks++; if ({out_src0_preg, out_src1_preg} !== {6'd32, 6'd33}) $display("FAIL flush_arch_srcs got=%h exp=%h", {out_src0_preg, out_src1_preg}, {6'd32, 6'd33}); else n_pass++;
    for (int r = 3; r <= 9; r++) begin
      drive_rename(r, r, 0, 1, 1, 0);
      model_rename(r, r, 0, 1, 1, 0, e);
      n_checks++; if (got !== e) $display("FAIL flush_map_r%0d got=%h exp=%h", r, got, e); else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    logic [29:0] e, first;
    do_reset();
    out_ready = 0;
    in_rs_addr = 1; in_uses_rs = 1; in_rw_addr = 4; in_uses_rw = 1; in_valid = 1;
    @(posedge clk); #1;
    model_rename(1, 0, 4, 1, 0, 1, e);
    first = bundle();
    n_checks++; if (first !== e || out_valid !== 1'b1) $display("FAIL bp_first got=%h v=%b exp=%h", first, out_valid, e); else n_pass++;
    for (int c = 0; c < 3; c++) begin
      n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready_%0d got=%b exp=0", c, in_ready); else n_pass++;
      @(posedge clk); #1;
      n_checks++; if (bundle() !== e || out_valid !== 1'b1) $display("FAIL bp_hold_%0d got=%h v=%b exp=%h", c, bundle(), out_valid, e); else n_pass++;
    end
    idle_inputs();
    out_ready = 1;
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL bp_drain got=%b exp=0", out_valid); else n_pass++;
    drive_rename(4, 0, 5, 1, 0, 1);
    model_rename(4, 0, 5, 1, 0, 1, e);
    n_checks++; if (got !== e) $display("FAIL bp_one_consumed got=%h exp=%h", got, e); else n_pass++;
  endtask

  task automatic test_random();
    logic [29:0] e;
    int op, rs, rt, rw;
    bit us, ut, uw, exp_rdy;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      op = $urandom_range(0, 99);
      if (op < 62) begin
        rs = $urandom_range(0, 31); rt = $urandom_range(0, 31); rw = $urandom_range(0, 31);
        us = 1'($urandom); ut = 1'($urandom); uw = ($urandom_range(0, 3) != 0);
        exp_rdy = model_ready(uw, rw);
        drive_rename(rs, rt, rw, us, ut, uw);
        n_checks++; if (ready_seen !== exp_rdy) $display("FAIL rand_ready_%0d got=%b exp=%b", n, ready_seen, exp_rdy); else n_pass++;
        if (exp_rdy && ready_seen) begin
          model_rename(rs, rt, rw, us, ut, uw, e);
          n_checks++; if (got !== e || got_valid !== 1'b1) $display("FAIL rand_out_%0d got=%h v=%b exp=%h", n, got, got_valid, e); else n_pass++;
        end
      end else if (op < 95) begin
        if (al_q.size() > 0) drive_retire();
      end else begin
        drive_flush($urandom_range(1, 31));
        n_checks++; if (out_valid !== 1'b0) $display("FAIL rand_flush_%0d got=%b exp=0", n, out_valid); else n_pass++;
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_same_reg();
    test_r0();
    test_fill();
    test_flush();
    test_backpressure();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
